gcc_point_src: RTL
==================

GCC_POINT_SRC -- requirements
Module: gcc_point_src

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning point-buffer capacity in entries (min 6, power of 2).
REQ-002 SHALL have port CLK  in  1  single clock; all state changes on posedge.
REQ-003 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports ld_valid in 1, ld_ready out 1, ld_x in 8, ld_y in 8, ld_w in 4; together these form the point-load handshake.
REQ-005 SHALL have port start  in  1  begin streaming the loaded points.
REQ-006 SHALL have ports Xi out 8, Yi out 8, Wi out 4; these are the point stream into the centroid block.
REQ-007 SHALL have port gcc_rst_n  out  1  active-low clear for the centroid block.
REQ-008 SHALL have ports READY_ in 1 (active-low result valid), Xc in 8, Yc in 8 (centroid results).
REQ-009 SHALL have ports res_valid out 1, res_x out 8, res_y out 8; these carry the captured centroid.
REQ-010 SHALL have ports busy out 1, done out 1 (1-cycle pulse), bad_start out 1 (1-cycle pulse).

Function
REQ-011 SHALL accept a point when ld_valid&&ld_ready; it SHALL store the point at wr_ptr and increment count; ld_ready SHALL be 1 only in IDLE with count<DEPTH.
REQ-012 SHALL use states IDLE, CLR, STREAM, DRAIN, DONE.
REQ-013 IDLE: start with count>=6 SHALL go to CLR; start with count<6 SHALL stay in IDLE and pulse bad_start next cycle.
REQ-014 CLR SHALL last exactly 1 cycle; gcc_rst_n SHALL be 0 during CLR only and 1 in all other states; rd_idx SHALL be cleared to 0.
REQ-015 STREAM: in each cycle i (0..count-1), Xi/Yi/Wi SHALL present buffer entry i combinationally from rd_idx; after count cycles the FSM SHALL go to DRAIN.
REQ-016 DRAIN SHALL last 1 cycle; Xi/Yi/Wi SHALL be 0 outside STREAM.
REQ-017 Capture: at the posedge ending STREAM cycle j>=6, or ending DRAIN, with READY_==0, Xc/Yc SHALL be registered to res_x/res_y and res_valid SHALL be 1 for the following cycle.
REQ-018 Results per run SHALL be count-5, in point order; result k SHALL correspond to the window of points k..k+5.
REQ-019 DONE SHALL pulse done for 1 cycle, then return to IDLE; buffer contents and count SHALL be retained, so start can replay them.
REQ-020 busy SHALL be 1 in CLR, STREAM, DRAIN and DONE.
REQ-021 start SHALL be ignored outside IDLE; ld_valid SHALL be ignored (ld_ready=0) outside IDLE.
REQ-022 A load and a start in the same IDLE cycle SHALL store the point, and count SHALL include it for the start>=6 test.
REQ-023 Full buffer: ld_ready SHALL be 0 and no overwrite or wrap SHALL occur.
REQ-024 A start with count==DEPTH SHALL stream all DEPTH points; rd_idx SHALL NOT wrap.

Reset
REQ-025 RESET SHALL force: state=IDLE, count=0, wr_ptr=0, rd_idx=0, res_valid=0, res_x=res_y=0, done=0, bad_start=0, busy=0, gcc_rst_n=0 during the reset cycle and 1 after.
REQ-026 RESET mid-run SHALL abort the run with no further res_valid; buffer RAM contents need not be cleared.

Configuration
REQ-027 With GCC_SRC_CHECK_EN defined, the block SHALL add output chk_err (1 bit, sticky until RESET), set if READY_==1 at any capture point in REQ-017 or if the result count at DONE != count-5.
REQ-028 Without GCC_SRC_CHECK_EN, chk_err and its logic SHALL be absent.

Structure
REQ-029 Package gcc_pkg SHALL hold: the state enum, point struct {x[7:0], y[7:0], w[3:0]}, and constant GCC_WIN=6.
REQ-030 Sub-module gcc_pt_buf SHALL be a DEPTH x 20-bit register file with 1 write port and 1 async read port.

Verification
REQ-031 Load (10,0,1),(20,0,1)..(60,0,1), start -> CLR 1 cycle, 6 STREAM cycles, exactly 1 res_valid with res_x=35, res_y=0, then done.
REQ-032 Load 8 points all (100,50,2), start -> 3 res_valid with res_x=100, res_y=50 each; busy low after done.
REQ-033 Load 5 points, start -> bad_start pulse, no CLR, state stays IDLE.
REQ-034 Load 16 points, hold ld_valid on a 17th -> ld_ready=0, count=16; start -> 11 results.
REQ-035 Assert RESET in STREAM cycle 3 -> next cycle idle, busy=0, count=0, no res_valid.
REQ-036 With GCC_SRC_CHECK_EN defined, force READY_=1 in the capture window -> chk_err=1, held until RESET.

Source files
------------

// File: rtl/gcc_pkg.sv
// Shared types and constants for the GCC point source.
package gcc_pkg;

  // Number of consecutive points per centroid window
  localparam int unsigned GCC_WIN = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] w;
  } point_t;

endpackage

// File: rtl/gcc_point_src_if.sv
// Point-load handshake between the loader and gcc_point_src.
interface gcc_point_src_if;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_x;
  logic [7:0] ld_y;
  logic [3:0] ld_w;

  modport master (output ld_valid, output ld_x, output ld_y, output ld_w, input ld_ready);
  modport slave  (input ld_valid, input ld_x, input ld_y, input ld_w, output ld_ready);
endinterface

// File: rtl/gcc_pt_buf.sv
// Point buffer: DEPTH entries, one synchronous write port, one async read port.
module gcc_pt_buf
  import gcc_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  point_t        wdata,
  input  logic [AW-1:0] raddr,
  output point_t        rdata
);

  point_t mem [DEPTH];

  // Write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gcc_point_src.sv
// GCC point source: buffers points, streams them into a centroid block and
// captures the sliding-window centroid results.
// Optional feature macro: GCC_SRC_CHECK_EN adds the sticky chk_err output.
module gcc_point_src
  import gcc_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  gcc_point_src_if.slave     ld,
  input  logic               start,
  output logic [7:0]         Xi,
  output logic [7:0]         Yi,
  output logic [3:0]         Wi,
  output logic               gcc_rst_n,
  input  logic               READY_,
  input  logic [7:0]         Xc,
  input  logic [7:0]         Yc,
  output logic               res_valid,
  output logic [7:0]         res_x,
  output logic [7:0]         res_y,
  output logic               busy,
  output logic               done,
  output logic               bad_start
`ifdef GCC_SRC_CHECK_EN
  ,
  output logic               chk_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_idx;
  point_t        rd_pt;
  point_t        wr_pt;
  logic          load;
  logic [CW-1:0] count_eff;
  logic          cap_pt;
  logic          last_pt;

  assign ld.ld_ready = (state == IDLE) && (count < CW'(DEPTH));
  assign load        = ld.ld_valid && ld.ld_ready;
  // A point loaded alongside start counts toward the minimum-window test
  assign count_eff   = count + CW'(load);
  assign cap_pt      = ((state == STREAM) && (CW'(rd_idx) >= CW'(GCC_WIN))) || (state == DRAIN);
  assign last_pt     = (CW'(rd_idx) == (count - CW'(1)));
  assign wr_pt       = '{x: ld.ld_x, y: ld.ld_y, w: ld.ld_w};

  gcc_pt_buf #(.DEPTH(DEPTH)) u_buf (
    .clk   (CLK),
    .we    (load),
    .waddr (wr_ptr),
    .wdata (wr_pt),
    .raddr (rd_idx),
    .rdata (rd_pt)
  );

  // Stream outputs are live only while streaming
  assign Xi        = (state == STREAM) ? rd_pt.x : 8'd0;
  assign Yi        = (state == STREAM) ? rd_pt.y : 8'd0;
  assign Wi        = (state == STREAM) ? rd_pt.w : 4'd0;
  assign gcc_rst_n = !RESET && (state != CLR);
  assign busy      = (state != IDLE);

  // Control FSM, load bookkeeping and result capture
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_idx    <= '0;
      res_valid <= 1'b0;
      res_x     <= 8'd0;
      res_y     <= 8'd0;
      done      <= 1'b0;
      bad_start <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      bad_start <= 1'b0;
      if (cap_pt && !READY_) begin
        res_valid <= 1'b1;
        res_x     <= Xc;
        res_y     <= Yc;
      end
      case (state)
        IDLE: begin
          if (load) begin
            count  <= count_eff;
            wr_ptr <= wr_ptr + AW'(1);
          end
          if (start) begin
            if (count_eff >= CW'(GCC_WIN)) state <= CLR;
            else                           bad_start <= 1'b1;
          end
        end
        CLR: begin
          rd_idx <= '0;
          state  <= STREAM;
        end
        STREAM: begin
          // Hold rd_idx on the last point so a full buffer never wraps it
          if (last_pt) state <= DRAIN;
          else         rd_idx <= rd_idx + AW'(1);
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCC_SRC_CHECK_EN
  logic [CW-1:0] res_cnt;

  // Sticky protocol checker: missing results at capture points or wrong total
  always_ff @(posedge CLK) begin
    if (RESET) begin
      chk_err <= 1'b0;
      res_cnt <= '0;
    end else begin
      if (state == CLR)             res_cnt <= '0;
      else if (cap_pt && !READY_)   res_cnt <= res_cnt + CW'(1);
      if (cap_pt && READY_)         chk_err <= 1'b1;
      if ((state == DONE) && (res_cnt != (count - CW'(GCC_WIN - 1)))) chk_err <= 1'b1;
    end
  end
`endif

endmodule
